cap_frame_demux: RTL and testbench

//  Receive-side unpacker for the channel-to-capacitor mux path. Capacitor-side words arrive as

---
 rtl/cap_frame_demux.sv | 154 +++++++++++++++
 tb/tb_cap_frame_demux.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_frame_demux.sv
// cap_frame_demux
// Reassembles frames that arrive as CAPACITOR_NUM-lane beats into a single
// CHANNEL_NUM-wide registered word. Each output channel also carries a flag
// that marks it as all-zeros or all-ones. The frame is handed to the
// channel-side consumer over a valid/ready handshake.
`timescale 1ns/1ps

module cap_frame_demux #(
  parameter int WIDTH         = 8,
  parameter int CHANNEL_NUM   = 128,
  parameter int CAPACITOR_NUM = 70
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sof,
  input  logic [WIDTH*CAPACITOR_NUM-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH*CHANNEL_NUM-1:0]     out_data,
  output logic [CHANNEL_NUM-1:0]           out_const,
  output logic                             err_sof
);

  localparam int BEATS  = (CHANNEL_NUM + CAPACITOR_NUM - 1) / CAPACITOR_NUM;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Every beat except the last is parked in the buffer. The last beat goes
  // straight from in_data into the output register.
  localparam int BUF_CH = (BEATS > 1) ? (BEATS - 1) * CAPACITOR_NUM : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]             beat_cnt_reg;
  logic [CNT_W-1:0]             beat_cnt_next;
  logic [WIDTH-1:0]             buf_reg [BUF_CH];
  logic                         out_valid_reg;
  logic [WIDTH*CHANNEL_NUM-1:0] out_data_reg;
  logic [CHANNEL_NUM-1:0]       out_const_reg;
  logic                         err_sof_reg;

  logic                         accept;
  logic                         sof_restart;
  logic                         sof_missing;
  logic                         load;
  logic                         buf_wr;
  logic [CNT_W-1:0]             buf_wr_beat;
  logic [WIDTH*CHANNEL_NUM-1:0] merged_data;
  logic [CHANNEL_NUM-1:0]       merged_const;

  // Classify the current handshake.
  // Cases: restart on SOF, drop on missing SOF, final load, or buffer write.
  always_comb begin
    accept      = in_valid & in_ready;
    sof_restart = accept & in_sof & (beat_cnt_reg != '0);
    sof_missing = accept & ~in_sof & (beat_cnt_reg == '0);
    load        = accept & ~sof_restart & ~sof_missing & (beat_cnt_reg == LAST_BEAT);
    buf_wr      = accept & ~sof_missing & ~load;
    buf_wr_beat = sof_restart ? '0 : beat_cnt_reg;
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
    end else begin
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Beat counter next state.
  // A misplaced SOF restarts the count at 1, because that beat becomes beat 0.
  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (sof_restart) begin
      beat_cnt_next = CNT_W'(1);
    end else if (load) begin
      beat_cnt_next = '0;
    end else if (buf_wr) begin
      beat_cnt_next = beat_cnt_reg + CNT_W'(1);
    end
  end

  // Handshake and output drive.
  // A final beat is held off only while a frame is still waiting for the consumer.
  always_comb begin
    in_ready  = (beat_cnt_reg != LAST_BEAT) | ~out_valid_reg | out_ready;
    out_valid = out_valid_reg;
    out_data  = out_data_reg;
    out_const = out_const_reg;
    err_sof   = err_sof_reg;
  end

  // Assembly buffer.
  // The buffer is not cleared on a framing error: any stale lane is
  // overwritten before the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < BUF_CH; c++) begin
        buf_reg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < BUF_CH; c++) begin
        if (buf_wr && (buf_wr_beat == CNT_W'(c / CAPACITOR_NUM))) begin
          buf_reg[c] <= in_data[(c % CAPACITOR_NUM)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Merge the buffered beats with the final beat. Padding lanes are never
  // referenced here.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_chan
      logic [WIDTH-1:0] chan;
      if ((gi / CAPACITOR_NUM) == (BEATS - 1)) begin : g_live
        assign chan = in_data[(gi % CAPACITOR_NUM)*WIDTH +: WIDTH];
      end else begin : g_buf
        assign chan = buf_reg[gi];
      end
      assign merged_data[gi*WIDTH +: WIDTH] = chan;
      assign merged_const[gi] = (chan == '0) ^ (chan == '1);
    end
  endgenerate

  // Output frame register.
  // A load in the same cycle as a consume replaces the old frame.
  // A consume with no load only drops valid; the data is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_const_reg <= '0;
    end else begin
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= merged_data;
        out_const_reg <= merged_const;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Registered framing-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sof_reg <= 1'b0;
    end else begin
      err_sof_reg <= sof_restart | sof_missing;
    end
  end

endmodule

// File: tb/tb_cap_frame_demux.sv
// Bench for cap_frame_demux.
// Directed and randomized beats are compared against a channel-array model.
`timescale 1ns/1ps

module tb_cap_frame_demux;
  localparam int W     = 8;
  localparam int CH    = 128;
  localparam int CAP   = 70;
  localparam int BEATS = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [W*CAP-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [W*CH-1:0]   out_data;
  logic [CH-1:0]     out_const;
  logic              err_sof;

  cap_frame_demux #(.WIDTH(W), .CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_const (out_const),
    .err_sof   (err_sof)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: frames as arrays of channels ----------------
  int           m_beat;
  bit           m_ov;
  bit           m_err;
  byte unsigned m_part [CH];
  byte unsigned m_out  [CH];
  bit [CH-1:0]  m_const;

  task automatic model_reset();
    m_beat  = 0;
    m_ov    = 0;
    m_err   = 0;
    m_const = '0;
    for (int c = 0; c < CH; c++) begin
      m_part[c] = 0;
      m_out[c]  = 0;
    end
  endtask

  function automatic bit model_ready(input bit rdy);
    return (m_beat != BEATS - 1) || !m_ov || rdy;
  endfunction

  task automatic model_store(input int b, input logic [W*CAP-1:0] d);
    for (int i = 0; i < CAP; i++) begin
      if (b * CAP + i < CH) m_part[b * CAP + i] = d[i*W +: W];
    end
  endtask

  task automatic model_clock(input bit v, input bit s, input logic [W*CAP-1:0] d, input bit rdy);
    bit acc;
    bit loaded;
    acc    = v && model_ready(rdy);
    loaded = 0;
    m_err  = 0;
    if (acc) begin
      if (s && m_beat != 0) begin
        m_err = 1;
        model_store(0, d);
        m_beat = 1;
      end else if (!s && m_beat == 0) begin
        m_err = 1;
      end else begin
        model_store(m_beat, d);
        if (m_beat == BEATS - 1) begin
          for (int c = 0; c < CH; c++) begin
            m_out[c]   = m_part[c];
            m_const[c] = (m_part[c] == 8'h00) || (m_part[c] == 8'hFF);
          end
          loaded = 1;
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
    end
    if (loaded) m_ov = 1;
    else if (rdy) m_ov = 0;
  endtask

  task automatic check_outputs();
    logic [W*CH-1:0] e;
    for (int c = 0; c < CH; c++) e[c*W +: W] = m_out[c];
    check("out_valid", out_valid, m_ov);
    check("err_sof", err_sof, m_err);
    check("out_const", out_const, m_const);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("out_data[%0d]", k), out_data[k*128 +: 128], e[k*128 +: 128]);
    end
  endtask

  // One clock: drive, check in_ready at negedge, advance model, check outputs.
  task automatic step(input bit v, input bit s, input logic [W*CAP-1:0] d, input bit rdy);
    in_valid  = v;
    in_sof    = s;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
    check("in_ready", in_ready, model_ready(rdy));
    @(posedge clk);
    model_clock(v, s, d, rdy);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst_n    = 0;
    #1;
    model_reset();
    check("rst_in_ready", in_ready, 1);
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*CAP-1:0] rand_beat();
    logic [W*CAP-1:0] d;
    for (int i = 0; i < CAP; i++) begin
      case ($urandom_range(0, 3))
        0:       d[i*W +: W] = 8'h00;
        1:       d[i*W +: W] = 8'hFF;
        default: d[i*W +: W] = W'($urandom);
      endcase
    end
    return d;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W*CAP-1:0] b0, b1, bz;
    int fv;
    rst_n     = 0;
    in_valid  = 0;
    in_sof    = 0;
    in_data   = '0;
    out_ready = 0;
    bz        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("init_in_ready", in_ready, 1);
    check_outputs();

    // Reset mid-frame, then a clean frame.
    step(1, 1, rand_beat(), 1);
    do_reset();
    step(1, 1, rand_beat(), 1);
    step(1, 0, rand_beat(), 1);
    check("t1_valid", out_valid, 1);
    step(0, 0, bz, 1);

    // Basic frame: channel c carries value c.
    for (int i = 0; i < CAP; i++) begin
      b0[i*W +: W] = W'(i);
      b1[i*W +: W] = (i < 58) ? W'(70 + i) : 8'hAA;
    end
    step(1, 1, b0, 0);
    step(1, 0, b1, 0);
    check("t2_valid", out_valid, 1);
    check("t2_const0", out_const[0], 1);
    check("t2_const1", out_const[1], 0);
    check("t2_ch69", out_data[69*W +: W], 69);
    check("t2_ch70", out_data[70*W +: W], 70);
    check("t2_ch127", out_data[127*W +: W], 127);
    step(0, 0, bz, 1);

    // Constant flags.
    for (int i = 0; i < CAP; i++) b0[i*W +: W] = W'(i + 16);
    b0[5*W +: W] = 8'hFF;
    b0[6*W +: W] = 8'h00;
    b0[7*W +: W] = 8'h80;
    step(1, 1, b0, 1);
    step(1, 0, rand_beat(), 1);
    check("t3_const5", out_const[5], 1);
    check("t3_const6", out_const[6], 1);
    check("t3_const7", out_const[7], 0);
    step(0, 0, bz, 1);

    // Backpressure: frame A held, frame B final beat stalls until consume.
    step(1, 1, rand_beat(), 0);
    step(1, 0, rand_beat(), 0);
    step(0, 0, bz, 0);
    b0 = rand_beat();
    b1 = rand_beat();
    step(1, 1, b0, 0);
    step(1, 0, b1, 0);
    check("t4_stall", in_ready, 0);
    step(1, 0, b1, 0);
    step(1, 0, b1, 1);
    check("t4_valid_kept", out_valid, 1);
    check("t4_b_ch0", out_data[0 +: W], b0[0 +: W]);
    check("t4_b_ch70", out_data[70*W +: W], b1[0 +: W]);
    step(0, 0, bz, 1);
    check("t4_consumed", out_valid, 0);

    // Framing errors.
    b0 = rand_beat();
    b1 = rand_beat();
    step(1, 1, rand_beat(), 1);
    step(1, 1, b0, 1);
    check("t5_err_restart", err_sof, 1);
    step(1, 0, b1, 1);
    check("t5_err_clear", err_sof, 0);
    check("t5_valid", out_valid, 1);
    check("t5_ch0", out_data[0 +: W], b0[0 +: W]);
    step(1, 0, rand_beat(), 1);
    check("t5_err_drop", err_sof, 1);
    step(0, 0, bz, 1);
    check("t5_err_once", err_sof, 0);

    // Throughput: 20 back-to-back frames.
    do_reset();
    fv = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, rand_beat(), 1);
      fv += int'(out_valid);
      step(1, 0, rand_beat(), 1);
      fv += int'(out_valid);
    end
    step(0, 0, bz, 1);
    fv += int'(out_valid);
    check("t6_frames", fv, 20);

    // Randomized traffic including framing errors and backpressure.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7,
           (m_beat == 0) ^ ($urandom_range(0, 15) == 0),
           rand_beat(),
           $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
